// File: rtl/control_step_sequencer.sv
// control_step_sequencer: microcoded T-step sequencer with wait stalls, conditional end, and sticky timeout/overrun flags.
// Each microcode word is {END, WAIT, CEND, control[CW_WIDTH-1:0]}. Only the control bits reach ctrl_out.
module control_step_sequencer #(
    parameter int CW_WIDTH  = 32,
    parameter int DEPTH     = 64,
    parameter int MAX_STEPS = 16,
    parameter int MAX_WAIT  = 8
) (
    input  logic                         Clock,
    input  logic                         clear,
    input  logic                         ucode_we,
    input  logic [$clog2(DEPTH)-1:0]     ucode_addr,
    input  logic [CW_WIDTH+2:0]          ucode_wdata,
    input  logic                         start,
    input  logic [$clog2(DEPTH)-1:0]     start_addr,
    input  logic                         mem_done,
    input  logic                         cond_in,
    output logic [CW_WIDTH-1:0]          ctrl_out,
    output logic [$clog2(MAX_STEPS)-1:0] step,
    output logic                         busy,
    output logic                         done,
    output logic                         err_timeout,
    output logic                         err_overrun
);
    localparam int AW = $clog2(DEPTH);
    localparam int SW = $clog2(MAX_STEPS);
    localparam int WW = $clog2(MAX_WAIT + 1);

    typedef enum logic [1:0] {IDLE, RUN, HALT} state_t;

    logic [CW_WIDTH+2:0] mem_q [DEPTH];

    state_t              state_q, state_d;
    logic [AW-1:0]       pc_q, pc_d, pc_inc;
    logic [WW-1:0]       wcnt_q, wcnt_d;
    logic [CW_WIDTH-1:0] ctrl_q, ctrl_d;
    logic [SW-1:0]       step_q, step_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                tmo_q, tmo_d;
    logic                ovr_q, ovr_d;
    logic                end_hit, wait_hit;

    // pc_inc is AW bits wide, so stepping past DEPTH-1 wraps to 0 for free
    assign pc_inc   = pc_q + AW'(1);
    assign end_hit  = mem_q[pc_q][CW_WIDTH+2] | (mem_q[pc_q][CW_WIDTH] & ~cond_in);
    assign wait_hit = mem_q[pc_q][CW_WIDTH+1] & ~mem_done;

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        wcnt_d  = wcnt_q;
        ctrl_d  = ctrl_q;
        step_d  = step_q;
        done_d  = 1'b0;
        tmo_d   = tmo_q;
        ovr_d   = ovr_q;
        case (state_q)
            IDLE: begin
                ctrl_d = '0;
                if (start) begin
                    pc_d    = start_addr;
                    ctrl_d  = mem_q[start_addr][CW_WIDTH-1:0];
                    step_d  = '0;
                    wcnt_d  = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                if (end_hit) begin
                    ctrl_d  = '0;
                    step_d  = '0;
                    done_d  = 1'b1;
                    state_d = IDLE;
                end else if (wait_hit) begin
                    wcnt_d = wcnt_q + WW'(1);
                    if (wcnt_q == WW'(MAX_WAIT - 1)) begin
                        tmo_d   = 1'b1;
                        ctrl_d  = '0;
                        state_d = HALT;
                    end
                end else if (step_q == SW'(MAX_STEPS - 1)) begin
                    ovr_d   = 1'b1;
                    ctrl_d  = '0;
                    state_d = HALT;
                end else begin
                    pc_d   = pc_inc;
                    step_d = step_q + SW'(1);
                    ctrl_d = mem_q[pc_inc][CW_WIDTH-1:0];
                    wcnt_d = '0;
                end
            end
            HALT: ctrl_d = '0;
            default: begin
                ctrl_d  = '0;
                state_d = IDLE;
            end
        endcase
        busy_d = (state_d == RUN);
    end

    always_ff @(posedge Clock) begin
        if (clear) begin
            state_q <= IDLE;
            pc_q    <= '0;
            wcnt_q  <= '0;
            ctrl_q  <= '0;
            step_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            tmo_q   <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            wcnt_q  <= wcnt_d;
            ctrl_q  <= ctrl_d;
            step_q  <= step_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            tmo_q   <= tmo_d;
            ovr_q   <= ovr_d;
        end
    end

    // Microcode survives clear; it is only writable while idle and not starting
    always_ff @(posedge Clock) begin
        if (!clear && state_q == IDLE && !start && ucode_we)
            mem_q[ucode_addr] <= ucode_wdata;
    end

    assign ctrl_out    = ctrl_q;
    assign step        = step_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign err_timeout = tmo_q;
    assign err_overrun = ovr_q;
endmodule

// File: tb/tb_control_step_sequencer.sv
// tb_control_step_sequencer: directed vectors with hand-computed expectations for control_step_sequencer.
module tb_control_step_sequencer;
    logic        Clock = 1'b0;
    logic        clear = 1'b1;
    logic        ucode_we = 1'b0;
    logic [5:0]  ucode_addr = '0;
    logic [34:0] ucode_wdata = '0;
    logic        start = 1'b0;
    logic [5:0]  start_addr = '0;
    logic        mem_done = 1'b0;
    logic        cond_in = 1'b1;
    logic [31:0] ctrl_out;
    logic [3:0]  step;
    logic        busy, done, err_timeout, err_overrun;
    int          checks = 0;
    int          failures = 0;

    control_step_sequencer dut (
        .Clock(Clock), .clear(clear), .ucode_we(ucode_we), .ucode_addr(ucode_addr),
        .ucode_wdata(ucode_wdata), .start(start), .start_addr(start_addr),
        .mem_done(mem_done), .cond_in(cond_in), .ctrl_out(ctrl_out), .step(step),
        .busy(busy), .done(done), .err_timeout(err_timeout), .err_overrun(err_overrun)
    );

    always #5 Clock = ~Clock;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge Clock);
        #1;
    endtask

    function automatic logic [34:0] uw(input logic e, input logic wt, input logic ce, input logic [31:0] c);
        return {e, wt, ce, c};
    endfunction

    task automatic wr(input logic [5:0] a, input logic [34:0] d);
        ucode_we = 1'b1;
        ucode_addr = a;
        ucode_wdata = d;
        tick;
        ucode_we = 1'b0;
    endtask

    task automatic go(input logic [5:0] a);
        start = 1'b1;
        start_addr = a;
        tick;
        start = 1'b0;
    endtask

    task automatic outs_zero(input string tag);
        check({tag, "_ctrl"}, ctrl_out, 0);
        check({tag, "_step"}, step, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_tmo"}, err_timeout, 0);
        check({tag, "_ovr"}, err_overrun, 0);
    endtask

    task automatic expect_word(input string tag, input logic [31:0] c, input logic [3:0] s);
        check({tag, "_ctrl"}, ctrl_out, c);
        check({tag, "_step"}, step, s);
        check({tag, "_busy"}, busy, 1);
        check({tag, "_done"}, done, 0);
    endtask

    task automatic expect_done(input string tag);
        check({tag, "_done"}, done, 1);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_ctrl"}, ctrl_out, 0);
    endtask

    initial begin
        tick;
        tick;
        clear = 1'b0;
        outs_zero("reset");

        // straight sequence 0x10..0x14, END on address 4
        for (int i = 0; i < 5; i++) wr(6'(i), uw(i == 4, 1'b0, 1'b0, 32'h10 + i));
        go(6'd0);
        for (int i = 0; i < 5; i++) begin
            expect_word($sformatf("straight%0d", i), 32'h10 + i, 4'(i));
            tick;
        end
        expect_done("straight_end");
        tick;
        check("straight_done_once", done, 0);
        check("straight_idle_ctrl", ctrl_out, 0);

        // wait stall: address 1 holds for 3 low mem_done cycles plus the release cycle
        wr(6'd1, uw(1'b0, 1'b1, 1'b0, 32'h11));
        mem_done = 1'b0;
        go(6'd0);
        expect_word("stall_w0", 32'h10, 4'd0);
        for (int i = 0; i < 4; i++) begin
            tick;
            expect_word($sformatf("stall_hold%0d", i), 32'h11, 4'd1);
        end
        mem_done = 1'b1;
        tick;
        expect_word("stall_resume2", 32'h12, 4'd2);
        tick;
        expect_word("stall_resume3", 32'h13, 4'd3);
        tick;
        expect_word("stall_resume4", 32'h14, 4'd4);
        tick;
        expect_done("stall_end");

        // conditional end on address 2; mem_done stays high so the wait step is zero-stall
        wr(6'd2, uw(1'b0, 1'b0, 1'b1, 32'h12));
        cond_in = 1'b0;
        go(6'd0);
        expect_word("cend0_w0", 32'h10, 4'd0);
        tick;
        expect_word("cend0_w1", 32'h11, 4'd1);
        tick;
        expect_word("cend0_w2", 32'h12, 4'd2);
        tick;
        expect_done("cend0_end");
        cond_in = 1'b1;
        go(6'd0);
        expect_word("restart_on_done", 32'h10, 4'd0);
        for (int i = 1; i < 5; i++) begin
            tick;
            expect_word($sformatf("cend1_w%0d", i), 32'h10 + i, 4'(i));
        end
        tick;
        expect_done("cend1_end");

        // clear mid-run at step 3, then a fresh start completes
        go(6'd0);
        tick;
        tick;
        tick;
        expect_word("midrun_s3", 32'h13, 4'd3);
        clear = 1'b1;
        tick;
        clear = 1'b0;
        outs_zero("midrun_clear");
        go(6'd0);
        expect_word("after_clear_w0", 32'h10, 4'd0);
        begin
            int n = 0;
            while (!done && n < 12) begin
                tick;
                n++;
            end
            check("after_clear_cycles", 64'(n), 5);
            check("after_clear_done", done, 1);
        end

        // wait timeout after MAX_WAIT stall cycles
        mem_done = 1'b0;
        go(6'd0);
        tick;
        expect_word("tmo_w1", 32'h11, 4'd1);
        for (int i = 0; i < 7; i++) tick;
        check("tmo_not_yet", err_timeout, 0);
        check("tmo_hold_ctrl", ctrl_out, 32'h11);
        tick;
        check("tmo_flag", err_timeout, 1);
        check("tmo_busy", busy, 0);
        check("tmo_ctrl", ctrl_out, 0);
        go(6'd0);
        tick;
        check("halt_start_busy", busy, 0);
        check("halt_start_ctrl", ctrl_out, 0);
        check("halt_sticky", err_timeout, 1);
        clear = 1'b1;
        tick;
        clear = 1'b0;
        outs_zero("tmo_clear");

        // overrun with pc wrap 63 -> 0
        for (int i = 0; i < 14; i++) wr(6'(i), uw(1'b0, 1'b0, 1'b0, 32'h100 + i));
        wr(6'd62, uw(1'b0, 1'b0, 1'b0, 32'h13e));
        wr(6'd63, uw(1'b0, 1'b0, 1'b0, 32'h13f));
        go(6'd62);
        for (int k = 0; k < 16; k++) begin
            expect_word($sformatf("ovr_k%0d", k), 32'h100 + ((62 + k) % 64), 4'(k));
            if (k < 15) tick;
        end
        check("ovr_not_yet", err_overrun, 0);
        tick;
        check("ovr_flag", err_overrun, 1);
        check("ovr_busy", busy, 0);
        check("ovr_ctrl", ctrl_out, 0);
        check("ovr_done", done, 0);
        go(6'd0);
        check("ovr_halt_ignores_start", busy, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
